// File: rtl/noc_wh_router.sv
// 5-port wormhole mesh router: per-input FIFOs, XY routing, round-robin switch
// allocation with per-output packet locks, credit flow control on every link.

module noc_wh_fifo #(
  parameter int FLIT_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] front,
  output logic              empty,
  output logic              ovf
);
  localparam int AW = $clog2(BUF_DEPTH);

  logic [FLIT_W-1:0] mem [BUF_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign front = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;

  // full wins over a same-cycle pop: the pushed flit is dropped
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (push && full)  ovf    <= 1'b1;
      if (pop)           rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module noc_wh_router #(
  parameter int   FLIT_W      = 32,
  parameter int   ARRAY_W     = 2,
  parameter int   BUF_DEPTH   = 4,
  parameter int   CREDIT_INIT = 4,
  localparam int  PORT_N      = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ARRAY_W-1:0]       my_xpos,
  input  logic [ARRAY_W-1:0]       my_ypos,
  input  logic [PORT_N-1:0]        in_vld,
  input  logic [PORT_N*FLIT_W-1:0] in_flit,
  output logic [PORT_N-1:0]        in_credit_o,
  output logic [PORT_N-1:0]        out_vld,
  output logic [PORT_N*FLIT_W-1:0] out_flit,
  input  logic [PORT_N-1:0]        out_credit_i,
  output logic [PORT_N-1:0]        ovf_o
);
  localparam int PW   = 3;
  localparam int CW   = $clog2(CREDIT_INIT + 1);
  localparam int HEAD = FLIT_W - 1;
  localparam int TAIL = FLIT_W - 2;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDIT_INIT);

  logic [PORT_N-1:0][FLIT_W-1:0] front;
  logic [PORT_N-1:0]             empty, pop, owns_lock;
  logic [PORT_N-1:0][PW-1:0]     route_c, route_q;
  logic [PORT_N-1:0]             lock_vld, gnt_vld;
  logic [PORT_N-1:0][PW-1:0]     lock_own, rr_ptr, gnt_in;
  logic [PORT_N-1:0][CW-1:0]     credit;

  noc_wh_fifo #(.FLIT_W(FLIT_W), .BUF_DEPTH(BUF_DEPTH)) u_fifo [PORT_N-1:0] (
    .clk(clk), .rst_n(rst_n), .push(in_vld), .din(in_flit), .pop(pop),
    .front(front), .empty(empty), .ovf(ovf_o)
  );

  // XY dimension order: resolve X first, then Y, then eject locally
  always_comb begin
    for (int i = 0; i < PORT_N; i++) begin
      if      (front[i][2*ARRAY_W-1:ARRAY_W] > my_xpos) route_c[i] = 3'd2;
      else if (front[i][2*ARRAY_W-1:ARRAY_W] < my_xpos) route_c[i] = 3'd4;
      else if (front[i][ARRAY_W-1:0] > my_ypos)         route_c[i] = 3'd1;
      else if (front[i][ARRAY_W-1:0] < my_ypos)         route_c[i] = 3'd3;
      else                                              route_c[i] = 3'd0;
    end
  end

  always_comb begin
    owns_lock = '0;
    for (int o = 0; o < PORT_N; o++)
      if (lock_vld[o]) owns_lock[lock_own[o]] = 1'b1;
  end

  // an input owns at most one lock and a head routes to one output, so each
  // input is granted by at most one output per cycle
  always_comb begin
    int c;
    c       = 0;
    gnt_vld = '0;
    gnt_in  = '0;
    for (int o = 0; o < PORT_N; o++) begin
      if (credit[o] != '0) begin
        if (lock_vld[o]) begin
          if (!empty[lock_own[o]] && route_q[lock_own[o]] == PW'(o)) begin
            gnt_vld[o] = 1'b1;
            gnt_in[o]  = lock_own[o];
          end
        end else begin
          for (int k = 0; k < PORT_N; k++) begin
            c = int'(rr_ptr[o]) + k;
            if (c >= PORT_N) c = c - PORT_N;
            if (!gnt_vld[o] && !empty[c] && front[c][HEAD] && !owns_lock[c] &&
                route_c[c] == PW'(o)) begin
              gnt_vld[o] = 1'b1;
              gnt_in[o]  = PW'(c);
            end
          end
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < PORT_N; o++)
      if (gnt_vld[o]) pop[gnt_in[o]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_vld     <= '0;
      out_flit    <= '0;
      in_credit_o <= '0;
      lock_vld    <= '0;
      lock_own    <= '0;
      rr_ptr      <= '0;
      route_q     <= '0;
      credit      <= {PORT_N{CRED_MAX}};
    end else begin
      out_vld     <= gnt_vld;
      in_credit_o <= pop;
      for (int o = 0; o < PORT_N; o++) begin
        if (gnt_vld[o]) out_flit[o*FLIT_W +: FLIT_W] <= front[gnt_in[o]];
        if (gnt_vld[o] && front[gnt_in[o]][HEAD]) begin
          lock_vld[o] <= !front[gnt_in[o]][TAIL];
          lock_own[o] <= gnt_in[o];
          rr_ptr[o]   <= (gnt_in[o] == PW'(PORT_N-1)) ? '0 : gnt_in[o] + 1'b1;
        end else if (gnt_vld[o] && front[gnt_in[o]][TAIL]) begin
          lock_vld[o] <= 1'b0;
        end
        case ({gnt_vld[o], out_credit_i[o]})
          2'b10:   credit[o] <= credit[o] - 1'b1;
          2'b01:   if (credit[o] != CRED_MAX) credit[o] <= credit[o] + 1'b1;
          default: ;
        endcase
      end
      for (int i = 0; i < PORT_N; i++)
        if (pop[i] && front[i][HEAD]) route_q[i] <= route_c[i];
    end
  end

  for (genvar g = 0; g < PORT_N; g++) begin : g_chk
    a_credit_sat: assert property (@(posedge clk) disable iff (rst_n)
      !(out_credit_i[g] && !gnt_vld[g] && credit[g] == CRED_MAX));
    a_orphan_body: assert property (@(posedge clk) disable iff (rst_n)
      !(!empty[g] && !front[g][HEAD] && !owns_lock[g]));
  end
endmodule

// File: tb/tb_noc_wh_router.sv
// Directed scenarios plus randomized traffic scored against a per-input
// ordering / XY-route / wormhole-contiguity reference model.

module tb_noc_wh_router;
  localparam int FW = 32;
  localparam int AW = 2;
  localparam int P  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] my_xpos = 2'd1, my_ypos = 2'd1;
  logic [P-1:0]  in_vld = '0;
  logic [P*FW-1:0] in_flit = '0;
  logic [P-1:0]  in_credit_o, out_vld, out_credit_i, ovf_o;
  logic [P*FW-1:0] out_flit;
  logic [P-1:0]  auto_cr = '1, man_cr = '0;

  // downstream sink: consumes at once (auto) or only on explicit pulses
  assign out_credit_i = (auto_cr & out_vld) | man_cr;

  noc_wh_router #(.FLIT_W(FW), .ARRAY_W(AW), .BUF_DEPTH(4), .CREDIT_INIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .in_vld(in_vld), .in_flit(in_flit), .in_credit_o(in_credit_o),
    .out_vld(out_vld), .out_flit(out_flit), .out_credit_i(out_credit_i),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int port; logic [FW-1:0] f; } obs_t;
  typedef struct { int src; int port; logic [FW-1:0] f; } exp_t;
  obs_t obs_q[$];
  obs_t ob;
  int   cred_cnt[P];
  int   checks = 0, failures = 0;

  always @(negedge clk)
    if (!rst_n)
      for (int o = 0; o < P; o++) begin
        if (out_vld[o]) begin
          ob.cyc = cyc; ob.port = o; ob.f = out_flit[o*FW +: FW];
          obs_q.push_back(ob);
        end
        if (in_credit_o[o]) cred_cnt[o]++;
      end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // flit: head, tail, pkt[29:22], idx[21:14], src[13:11], dest X[3:2], dest Y[1:0]
  function automatic logic [FW-1:0] mk(bit h, bit t, int src, int pkt, int idx, int dx, int dy);
    return {h, t, 8'(pkt), 8'(idx), 3'(src), 7'd0, 2'(dx), 2'(dy)};
  endfunction
  function automatic int src_of(logic [FW-1:0] f); return int'(f[13:11]); endfunction
  function automatic int idx_of(logic [FW-1:0] f); return int'(f[21:14]); endfunction
  function automatic int pkt_of(logic [FW-1:0] f); return int'(f[29:22]); endfunction

  function automatic int xy_port(int dx, int dy, int mx, int my);
    if (dx > mx) return 2;
    if (dx < mx) return 4;
    if (dy > my) return 1;
    if (dy < my) return 3;
    return 0;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic set_in(int i, logic [FW-1:0] f);
    in_vld[i] = 1'b1;
    in_flit[i*FW +: FW] = f;
  endtask
  task automatic clr_in(); in_vld = '0; endtask

  task automatic do_reset();
    rst_n = 1'b1; in_vld = '0; man_cr = '0;
    tick();
    rst_n = 1'b0;
    obs_q.delete();
    for (int i = 0; i < P; i++) cred_cnt[i] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_vld !== '0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (out_flit !== '0) begin failures++; $display("FAIL reset_out_flit got=%h exp=0", out_flit); end
    checks++; if (in_credit_o !== '0) begin failures++; $display("FAIL reset_in_credit got=%b exp=0", in_credit_o); end
    checks++; if (ovf_o !== '0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
  endtask

  task automatic test_basic();
    logic [FW-1:0] exp[3];
    int d0 = 0;
    do_reset();
    for (int k = 0; k < 3; k++) exp[k] = mk(k == 0, k == 2, 4, 1, k, 3, 1);
    for (int k = 0; k < 3; k++) begin
      set_in(4, exp[k]);
      if (k == 0) d0 = cyc;
      tick();
    end
    clr_in();
    repeat (6) tick();
    checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].port !== 2 || obs_q[k].f !== exp[k] || obs_q[k].cyc !== d0 + 2 + k) begin
        failures++;
        $display("FAIL basic_flit%0d got=port%0d/%h/cyc%0d exp=port2/%h/cyc%0d",
                 k, obs_q[k].port, obs_q[k].f, obs_q[k].cyc, exp[k], d0 + 2 + k);
      end
    end
    checks++; if (cred_cnt[4] !== 3) begin failures++; $display("FAIL basic_credits got=%0d exp=3", cred_cnt[4]); end
  endtask

  task automatic test_rr();
    int d0, d1;
    do_reset();
    d0 = cyc;
    for (int k = 0; k < 3; k++) begin
      set_in(0, mk(k == 0, k == 2, 0, 2, k, 3, 1));
      set_in(1, mk(k == 0, k == 2, 1, 3, k, 3, 1));
      tick();
    end
    clr_in();
    repeat (8) tick();
    checks++; if (obs_q.size() !== 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", obs_q.size()); end
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].port !== 2 || src_of(obs_q[k].f) !== k / 3 || idx_of(obs_q[k].f) !== k % 3 ||
          obs_q[k].cyc !== d0 + 2 + k) begin
        failures++;
        $display("FAIL rr_order%0d got=port%0d/src%0d/idx%0d/cyc%0d exp=port2/src%0d/idx%0d/cyc%0d",
                 k, obs_q[k].port, src_of(obs_q[k].f), idx_of(obs_q[k].f), obs_q[k].cyc,
                 k / 3, k % 3, d0 + 2 + k);
      end
    end
    // pointer now sits at 2, so input 2 beats input 1
    obs_q.delete();
    set_in(1, mk(1, 1, 1, 4, 0, 3, 1));
    set_in(2, mk(1, 1, 2, 5, 0, 3, 1));
    d1 = cyc;
    tick(); clr_in();
    repeat (4) tick();
    checks++;
    if (obs_q.size() !== 2) begin failures++; $display("FAIL rr_ptr_count got=%0d exp=2", obs_q.size()); end
    else begin
      checks++;
      if (src_of(obs_q[0].f) !== 2 || obs_q[0].cyc !== d1 + 2 || src_of(obs_q[1].f) !== 1 || obs_q[1].cyc !== d1 + 3) begin
        failures++;
        $display("FAIL rr_ptr_order got=src%0d@%0d,src%0d@%0d exp=src2@%0d,src1@%0d",
                 src_of(obs_q[0].f), obs_q[0].cyc, src_of(obs_q[1].f), obs_q[1].cyc, d1 + 2, d1 + 3);
      end
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    auto_cr[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_in(4, mk(k == 0, k == 5, 4, 6, k, 3, 1));
      tick();
    end
    clr_in();
    repeat (8) tick();
    checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", obs_q.size()); end
    checks++; if (ovf_o !== '0) begin failures++; $display("FAIL stall_ovf got=%b exp=0", ovf_o); end
    man_cr[2] = 1'b1; tick(); man_cr = '0;
    repeat (5) tick();
    checks++; if (obs_q.size() !== 5) begin failures++; $display("FAIL stall_release got=%0d exp=5", obs_q.size()); end
    if (obs_q.size() >= 5) begin
      checks++;
      if (idx_of(obs_q[4].f) !== 4) begin failures++; $display("FAIL stall_release_idx got=%0d exp=4", idx_of(obs_q[4].f)); end
    end
    auto_cr[2] = 1'b1;
  endtask

  task automatic test_overflow();
    do_reset();
    auto_cr[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(0, mk(k == 0, k == 3, 0, 7, k, 1, 0));
      tick();
    end
    clr_in();
    repeat (6) tick();
    checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL ovf_drain got=%0d exp=4", obs_q.size()); end
    obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      set_in(1, mk(k == 0, 0, 1, 8, k, 1, 0));
      tick();
    end
    clr_in();
    @(negedge clk);
    checks++; if (ovf_o !== '0) begin failures++; $display("FAIL ovf_at_full got=%b exp=00000", ovf_o); end
    tick();
    set_in(1, mk(0, 0, 1, 8, 4, 1, 0));
    tick(); clr_in(); tick();
    checks++; if (ovf_o !== 5'b00010) begin failures++; $display("FAIL ovf_set got=%b exp=00010", ovf_o); end
    checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL ovf_no_credit_sent got=%0d exp=0", obs_q.size()); end
    man_cr[3] = 1'b1; tick(); man_cr = '0;
    repeat (4) tick();
    checks++; if (ovf_o !== 5'b00010) begin failures++; $display("FAIL ovf_sticky got=%b exp=00010", ovf_o); end
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL ovf_one_credit got=%0d exp=1", obs_q.size()); end
    auto_cr[3] = 1'b1;
  endtask

  task automatic test_single();
    int d0;
    int exp_src[3] = '{3, 2, 2};
    do_reset();
    set_in(3, mk(1, 1, 3, 9, 0, 1, 1));
    d0 = cyc;
    tick(); clr_in();
    set_in(2, mk(1, 0, 2, 10, 0, 1, 1)); tick();
    set_in(2, mk(0, 1, 2, 10, 1, 1, 1)); tick();
    clr_in();
    repeat (5) tick();
    checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL single_count got=%0d exp=3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].port !== 0 || src_of(obs_q[k].f) !== exp_src[k] || obs_q[k].cyc !== d0 + 2 + k) begin
        failures++;
        $display("FAIL single_flit%0d got=port%0d/src%0d/cyc%0d exp=port0/src%0d/cyc%0d",
                 k, obs_q[k].port, src_of(obs_q[k].f), obs_q[k].cyc, exp_src[k], d0 + 2 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(4, mk(1, 0, 4, 11, 0, 3, 1)); tick();
    set_in(4, mk(0, 0, 4, 11, 1, 3, 1)); tick();
    clr_in();
    rst_n = 1'b1; tick(); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_vld !== '0) begin failures++; $display("FAIL midrst_out_vld got=%b exp=0", out_vld); end
    checks++; if (in_credit_o !== '0) begin failures++; $display("FAIL midrst_credit got=%b exp=0", in_credit_o); end
    obs_q.delete();
    tick();
    auto_cr[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(4, mk(k == 0, k == 3, 4, 12, k, 3, 1));
      tick();
    end
    clr_in();
    repeat (8) tick();
    checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL midrst_count got=%0d exp=4", obs_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      checks++;
      if (pkt_of(obs_q[k].f) !== 12 || idx_of(obs_q[k].f) !== k || obs_q[k].port !== 2) begin
        failures++;
        $display("FAIL midrst_flit%0d got=pkt%0d/idx%0d/port%0d exp=pkt12/idx%0d/port2",
                 k, pkt_of(obs_q[k].f), idx_of(obs_q[k].f), obs_q[k].port, k);
      end
    end
    auto_cr[2] = 1'b1;
  endtask

  task automatic test_random();
    exp_t exp_q[$];
    exp_t e;
    int up_cred[P], pend[P], rem[P], pdx[P], pdy[P], pidx[P], pid[P], open_src[P];
    int id = 20, n = 0, jj, s, mx, my;
    bit busy, ok;
    logic [FW-1:0] f;
    my_xpos = 2'($urandom_range(0, 3));
    my_ypos = 2'($urandom_range(0, 3));
    mx = int'(my_xpos); my = int'(my_ypos);
    auto_cr = '0;
    do_reset();
    for (int i = 0; i < P; i++) begin
      up_cred[i] = 4; pend[i] = 0; rem[i] = 0; pidx[i] = 0; pid[i] = 0; open_src[i] = -1;
      pdx[i] = 0; pdy[i] = 0;
    end
    busy = 1'b1;
    while ((n < 400 || busy) && n < 3000) begin
      @(negedge clk);
      for (int o = 0; o < P; o++) begin
        if (in_credit_o[o]) up_cred[o]++;
        if (out_vld[o]) begin
          pend[o]++;
          f = out_flit[o*FW +: FW];
          s = src_of(f);
          jj = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (jj < 0 && exp_q[j].src == s) jj = j;
          ok = (jj >= 0) && exp_q[jj].port == o && exp_q[jj].f == f;
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL rand_route port%0d got=%h exp=%h", o, f, (jj >= 0) ? exp_q[jj].f : '0);
          end
          if (jj >= 0) exp_q.delete(jj);
          checks++;
          if (f[FW-1] ? (open_src[o] != -1) : (open_src[o] != s)) begin
            failures++;
            $display("FAIL rand_wormhole port%0d got=src%0d exp=open%0d", o, s, open_src[o]);
          end
          open_src[o] = f[FW-2] ? -1 : s;
        end
      end
      tick();
      in_vld = '0; man_cr = '0;
      for (int o = 0; o < P; o++)
        if (pend[o] > 0 && $urandom_range(0, 3) != 0) begin man_cr[o] = 1'b1; pend[o]--; end
      for (int i = 0; i < P; i++) begin
        if (rem[i] == 0 && n < 400 && $urandom_range(0, 2) == 0) begin
          rem[i] = $urandom_range(1, 4);
          pdx[i] = $urandom_range(0, 3); pdy[i] = $urandom_range(0, 3);
          pidx[i] = 0; pid[i] = id; id = (id + 1) % 256;
        end
        if (rem[i] > 0 && up_cred[i] > 0 && $urandom_range(0, 3) != 0) begin
          f = mk(pidx[i] == 0, rem[i] == 1, i, pid[i], pidx[i], pdx[i], pdy[i]);
          set_in(i, f);
          e.src = i; e.port = xy_port(pdx[i], pdy[i], mx, my); e.f = f;
          exp_q.push_back(e);
          up_cred[i]--; rem[i]--; pidx[i]++;
        end
      end
      busy = exp_q.size() != 0;
      for (int i = 0; i < P; i++) if (rem[i] != 0) busy = 1'b1;
      n++;
    end
    in_vld = '0; man_cr = '0;
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_drain got=%0d left exp=0", exp_q.size()); end
    checks++; if (ovf_o !== '0) begin failures++; $display("FAIL rand_ovf got=%b exp=0", ovf_o); end
    obs_q.delete();
    auto_cr = '1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_credit_stall();
    test_overflow();
    test_single();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
